// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-bank sequencer: funsel op codes,
// FSM state type and the one-hot enable helper.
package reg_ctrl_pkg;

    localparam logic [1:0] OP_DEC   = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves only when a grant
// is actually taken, so an abandoned request does not cost a turn.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio_b;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio_b ? 2'b10 : 2'b01;
        end
    end

    // Serving A hands priority to B, serving B hands it back to A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (accept) begin
            prio_b <= grant[0];
        end
    end

endmodule

// File: rtl/reg_bank_sequencer.sv
// Arbitrates two command requesters onto a four-register bank and expands
// repeated INC/DEC commands into multi-cycle enable bursts.
module reg_bank_sequencer
    import reg_ctrl_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_sel,
    input  logic [1:0]       a_op,
    input  logic [N-1:0]     a_data,
    input  logic [CNT_W-1:0] a_count,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_sel,
    input  logic [1:0]       b_op,
    input  logic [N-1:0]     b_data,
    input  logic [CNT_W-1:0] b_count,
    output logic [3:0]       reg_enable,
    output logic [1:0]       reg_funsel,
    output logic [N-1:0]     reg_load,
    output logic             busy,
    output logic             done,
    output logic             done_src
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             src;
    logic [1:0]       req;
    logic [1:0]       grant;
    logic             accept;
    logic [1:0]       cmd_sel;
    logic [1:0]       cmd_op;
    logic [N-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic [CNT_W-1:0] eff_count;

    assign req     = {b_valid, a_valid} & {2{state == IDLE}};
    assign accept  = |grant;
    assign a_ready = grant[0];
    assign b_ready = grant[1];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // LOAD/CLEAR are single-shot; a zero repeat count still runs once.
    always_comb begin
        cmd_sel   = grant[1] ? b_sel   : a_sel;
        cmd_op    = grant[1] ? b_op    : a_op;
        cmd_data  = grant[1] ? b_data  : a_data;
        cmd_count = grant[1] ? b_count : a_count;
        eff_count = CNT_W'(1);
        if ((cmd_op == OP_INC || cmd_op == OP_DEC) && cmd_count != '0) begin
            eff_count = cmd_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            src        <= 1'b0;
            reg_enable <= 4'b0000;
            reg_funsel <= OP_DEC;
            reg_load   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_src   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= EXEC;
                        busy       <= 1'b1;
                        reg_enable <= onehot4(cmd_sel);
                        reg_funsel <= cmd_op;
                        reg_load   <= (cmd_op == OP_LOAD) ? cmd_data : '0;
                        remaining  <= eff_count;
                        src        <= grant[1];
                    end
                end
                EXEC: begin
                    if (remaining == CNT_W'(1)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        reg_enable <= 4'b0000;
                        reg_funsel <= OP_DEC;
                        reg_load   <= '0;
                        done       <= 1'b1;
                        done_src   <= src;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Directed bench for reg_bank_sequencer with a behavioural four-register
// bank driven by the sequencer outputs.
module tb_reg_bank_sequencer;
    import reg_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [1:0] a_sel, b_sel, a_op, b_op;
    logic [7:0] a_data, b_data;
    logic [3:0] a_count, b_count;
    logic [3:0] reg_enable;
    logic [1:0] reg_funsel;
    logic [7:0] reg_load;
    logic       busy, done, done_src;

    logic [7:0] bank [4];
    int tests;
    int failures;

    reg_bank_sequencer #(.N(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_sel      (a_sel),
        .a_op       (a_op),
        .a_data     (a_data),
        .a_count    (a_count),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_sel      (b_sel),
        .b_op       (b_op),
        .b_data     (b_data),
        .b_count    (b_count),
        .reg_enable (reg_enable),
        .reg_funsel (reg_funsel),
        .reg_load   (reg_load),
        .busy       (busy),
        .done       (done),
        .done_src   (done_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register bank: wrapping arithmetic, no reset.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reg_enable[i]) begin
                case (reg_funsel)
                    2'b00:   bank[i] <= bank[i] - 8'd1;
                    2'b01:   bank[i] <= bank[i] + 8'd1;
                    2'b10:   bank[i] <= reg_load;
                    default: bank[i] <= 8'h00;
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit side, input logic [1:0] sel, input logic [1:0] op,
                                 input logic [7:0] data, input logic [3:0] count);
        if (side == 1'b0) begin
            a_valid = 1'b1; a_sel = sel; a_op = op; a_data = data; a_count = count;
        end else begin
            b_valid = 1'b1; b_sel = sel; b_op = op; b_data = data; b_count = count;
        end
    endtask

    initial begin
        tests = 0;
        failures = 0;
        for (int i = 0; i < 4; i++) bank[i] = 8'h00;
        rst = 1'b1;
        a_valid = 1'b0; a_sel = 2'd0; a_op = 2'd0; a_data = 8'h00; a_count = 4'd0;
        b_valid = 1'b0; b_sel = 2'd0; b_op = 2'd0; b_data = 8'h00; b_count = 4'd0;

        @(negedge clk);
        checkOutput("rst_enable", reg_enable, 4'b0000);
        checkOutput("rst_funsel", reg_funsel, 2'b00);
        checkOutput("rst_load", reg_load, 8'h00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_done_src", done_src, 1'b0);
        checkOutput("rst_a_ready", a_ready, 1'b0);
        checkOutput("rst_b_ready", b_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // LOAD 0x5A into reg 2
        applyStimulus(1'b0, 2'd2, OP_LOAD, 8'h5A, 4'd0);
        #1;
        checkOutput("load_a_ready", a_ready, 1'b1);
        checkOutput("load_b_ready", b_ready, 1'b0);
        @(negedge clk);
        a_valid = 1'b0;
        checkOutput("load_enable", reg_enable, 4'b0100);
        checkOutput("load_funsel", reg_funsel, 2'b10);
        checkOutput("load_bus", reg_load, 8'h5A);
        checkOutput("load_busy", busy, 1'b1);
        @(negedge clk);
        checkOutput("load_enable_off", reg_enable, 4'b0000);
        checkOutput("load_done", done, 1'b1);
        checkOutput("load_done_src", done_src, 1'b0);
        checkOutput("load_reg2", bank[2], 8'h5A);

        // CLEAR reg 1, then INC reg 1 three times
        applyStimulus(1'b0, 2'd1, OP_CLEAR, 8'hFF, 4'd7);
        @(negedge clk);
        a_valid = 1'b0;
        checkOutput("clear_load_zero", reg_load, 8'h00);
        @(negedge clk);
        applyStimulus(1'b0, 2'd1, OP_INC, 8'h00, 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_valid = 1'b0;
            checkOutput("inc_enable", reg_enable, 4'b0010);
            checkOutput("inc_funsel", reg_funsel, 2'b01);
            checkOutput("inc_done_low", done, 1'b0);
        end
        @(negedge clk);
        checkOutput("inc_done", done, 1'b1);
        checkOutput("inc_busy_off", busy, 1'b0);
        checkOutput("inc_reg1", bank[1], 8'h03);

        // DEC reg 0 with count 0 runs once and wraps
        applyStimulus(1'b0, 2'd0, OP_DEC, 8'h00, 4'd0);
        @(negedge clk);
        a_valid = 1'b0;
        checkOutput("dec_enable", reg_enable, 4'b0001);
        @(negedge clk);
        checkOutput("dec_done", done, 1'b1);
        checkOutput("dec_busy_off", busy, 1'b0);
        checkOutput("dec_reg0", bank[0], 8'hFF);

        // B arrives while A's command is executing
        applyStimulus(1'b0, 2'd0, OP_LOAD, 8'h11, 4'd0);
        #1;
        checkOutput("wait_a_ready", a_ready, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        applyStimulus(1'b1, 2'd0, OP_LOAD, 8'h22, 4'd0);
        #1;
        checkOutput("wait_b_ready_busy", b_ready, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("wait_a_done", done, 1'b1);
        checkOutput("wait_a_done_src", done_src, 1'b0);
        checkOutput("wait_b_ready_idle", b_ready, 1'b1);
        checkOutput("wait_reg0_a", bank[0], 8'h11);
        @(negedge clk);
        b_valid = 1'b0;
        checkOutput("wait_b_enable", reg_enable, 4'b0001);
        checkOutput("wait_b_load", reg_load, 8'h22);
        @(negedge clk);
        checkOutput("wait_b_done", done, 1'b1);
        checkOutput("wait_b_done_src", done_src, 1'b1);
        checkOutput("wait_reg0_b", bank[0], 8'h22);

        // Both requesters continuously valid: A, B, A, B
        applyStimulus(1'b0, 2'd3, OP_INC, 8'h00, 4'd2);
        applyStimulus(1'b1, 2'd3, OP_INC, 8'h00, 4'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("rr_a_ready", a_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            checkOutput("rr_b_ready", b_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
            if (i > 0) begin
                checkOutput("rr_done", done, 1'b1);
                checkOutput("rr_done_src", done_src, ((i - 1) % 2 == 1) ? 1'b1 : 1'b0);
            end
            @(negedge clk);
            checkOutput("rr_busy1", busy, 1'b1);
            checkOutput("rr_ready_busy", {a_ready, b_ready}, 2'b00);
            @(negedge clk);
            checkOutput("rr_busy2", busy, 1'b1);
            @(negedge clk);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        checkOutput("rr_last_done", done, 1'b1);
        checkOutput("rr_last_done_src", done_src, 1'b1);
        checkOutput("rr_reg3", bank[3], 8'h08);

        // Reset during the second cycle of an INC x5 burst
        applyStimulus(1'b0, 2'd1, OP_INC, 8'h00, 4'd5);
        @(negedge clk);
        a_valid = 1'b0;
        checkOutput("abort_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_enable", reg_enable, 4'b0000);
        checkOutput("abort_funsel", reg_funsel, 2'b00);
        checkOutput("abort_busy_off", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_reg1", bank[1], 8'h04);
        @(negedge clk);
        checkOutput("abort_no_done", done, 1'b0);
        applyStimulus(1'b0, 2'd1, OP_LOAD, 8'h33, 4'd0);
        applyStimulus(1'b1, 2'd2, OP_LOAD, 8'h44, 4'd0);
        #1;
        checkOutput("post_rst_a_ready", a_ready, 1'b1);
        checkOutput("post_rst_b_ready", b_ready, 1'b0);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        checkOutput("post_rst_enable", reg_enable, 4'b0010);
        checkOutput("post_rst_load", reg_load, 8'h33);
        @(negedge clk);
        checkOutput("post_rst_done", done, 1'b1);
        checkOutput("post_rst_done_src", done_src, 1'b0);
        checkOutput("post_rst_reg1", bank[1], 8'h33);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_sequencer.md
# reg_bank_sequencer

Sequencing controller for a bank of four `register` instances sharing one load bus. Two requesters (A and B) submit register commands over valid/ready handshakes; the block arbitrates round-robin and drives the bank's one-hot enables, shared `funsel` and shared `load` bus. Repeated increment/decrement commands are expanded into multi-cycle bursts.

## Interface
- `N`, default 8: data width of registers and load bus.
- `CNT_W`, default 4: width of repeat-count field.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` / `b_valid` in 1: requester has a command.
- `a_ready` / `b_ready` out 1: command accepted this cycle when valid && ready.
- `a_sel` / `b_sel` in 2: target register index 0..3.
- `a_op` / `b_op` in 2: operation; 00 DEC, 01 INC, 10 LOAD, 11 CLEAR (register `funsel` encoding).
- `a_data` / `b_data` in N: load value; used only by LOAD.
- `a_count` / `b_count` in CNT_W: repeat count for INC/DEC.
- `reg_enable` out 4: one-hot enable to registers 0..3.
- `reg_funsel` out 2: shared function select.
- `reg_load` out N: shared load bus.
- `busy` out 1: high in EXEC.
- `done` out 1: one-cycle pulse after a command completes.
- `done_src` out 1: requester of the completed command (0 = A, 1 = B); valid with `done`.

## Operation
- FSM states: IDLE, EXEC.
- IDLE:
  - Arbiter grants at most one requester.
  - Only the granted side sees ready = 1.
  - Handshake latches sel, op, data and an effective count into internal registers, then moves to EXEC.
- Arbitration:
  - Only one valid: that side is granted.
  - Both valid: the side not served last is granted.
  - Priority pointer updates only on a handshake; after reset the pointer favours A.
- Effective count:
  - INC/DEC: `count`, with 0 treated as 1.
  - LOAD/CLEAR: always 1.
- EXEC:
  - `reg_enable` = one-hot(sel); `reg_funsel` = op; `reg_load` = data (0 for non-LOAD ops).
  - Remaining-count register decrements each cycle.
  - When remaining = 1, the next state is IDLE and `done` is registered high for the following cycle.
- Outside EXEC: `reg_enable` = 0, `reg_funsel` = 00, `reg_load` = 0.
- Register arithmetic wraps; the sequencer does not detect overflow.
- `a_ready`/`b_ready` are combinational from state, pointer and valids.
- Requesters must hold command fields stable while valid && !ready.

## Timing
- Reset values:
  - state IDLE, pointer = A.
  - `a_ready` = `b_ready` = 0 unless a valid is present in IDLE.
  - `reg_enable` 0, `reg_funsel` 00, `reg_load` 0, `busy` 0, `done` 0, `done_src` 0.
- Latency: handshake in cycle t; EXEC occupies t+1 .. t+k (k = effective count); register updates at the edges ending those cycles.
- `done`: high in cycle t+k+1, which is an IDLE cycle; a new handshake may occur in that same cycle.
- Throughput: one command per k+1 cycles.
- Back-to-back with both requesters always valid: strict A, B, A, B alternation.
- Reset asserted mid-EXEC:
  - Outputs clear immediately (async); the burst is abandoned.
  - No `done` is produced.
  - Registers keep whatever increments were already applied.
- A valid deasserted without a handshake is legal and ignored.

## Structure
- Package `reg_ctrl_pkg`:
  - op encodings `OP_DEC`, `OP_INC`, `OP_LOAD`, `OP_CLEAR`.
  - state enum {IDLE, EXEC}.
  - function `onehot4(sel)`.
- Sub-module `rr_arbiter2`: two-request round-robin with pointer register, inputs req[1:0] and accept, output grant[1:0].
- Top-level holds the FSM, command latch and remaining counter.

## Test plan
- Reset, then A: LOAD 0x5A into reg 2.
  - a_ready high in cycle 0.
  - reg_enable = 0100, funsel = 10, load = 0x5A for exactly 1 cycle.
  - done with done_src = 0 the next cycle; register 2 reads 0x5A.
- A: INC reg 1, count 3, after CLEAR.
  - EXEC for 3 cycles with enable 0010 and funsel 01.
  - Register 1 = 3; done after the 3rd cycle.
- DEC reg 0, count 0 from 0x00.
  - Exactly 1 EXEC cycle; register wraps to 0xFF.
- A and B valid continuously, each issuing INC count 2 to reg 3.
  - Grants alternate A, B, A, B starting with A.
  - done_src sequence 0, 1, 0, 1; each command takes 3 cycles.
- rst pulsed in the 2nd cycle of an INC count-5 burst.
  - Outputs 0 during reset; no done.
  - Register holds 1 increment; the next command is accepted normally.
- B valid while busy with A's command.
  - b_ready stays low until IDLE, then B is accepted in the done cycle.
